truth_vector_checker: RTL

Upstream stimulus-and-check stage for the 3-input combinational `sillyfunction` block. On `start`, it walks all 2^N_IN input vectors onto a, b and c. After each vector has settled, it samples y, compares it with a parameterised truth table, and counts mismatches. It is synthesizable, so the self-check of the combinational block can run on hardware as well as in simulation.

---
 rtl/truth_vector_checker.sv | 127 ++++++++++++
 1 files changed

// File: rtl/truth_vector_checker.sv
// rtl/truth_vector_checker.sv - sweeps all a/b/c vectors into a 3-input block and counts y mismatches
// Optional build macro: STOP_ON_FAIL_EN (end the sweep at the first mismatch)
module truth_vector_checker #(
  parameter int                 N_IN     = 3,
  parameter logic [2**N_IN-1:0] EXPECTED = 8'h31,
  parameter int                 SETTLE   = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  output logic            a,
  output logic            b,
  output logic            c,
  input  logic            y,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail_vec,
  output logic            first_fail_valid
);

  localparam int              CW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   CMAX = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] LAST = '1;

  typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

  state_t          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N_IN:0]   err_q, err_d;
  logic [N_IN-1:0] ffv_q, ffv_d;
  logic            ffvalid_q, ffvalid_d;
  logic [N_IN-1:0] abc_q, abc_d;
  logic            mismatch;

  // Next-state logic: sequencing, mismatch accounting and the registered vector drive
  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    ffv_d     = ffv_q;
    ffvalid_d = ffvalid_q;
    mismatch  = (y != EXPECTED[vec_q]);
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = APPLY;
          vec_d     = '0;
          cnt_d     = '0;
          err_d     = '0;
          ffv_d     = '0;
          ffvalid_d = 1'b0;
        end
      end
      APPLY: begin
        if (cnt_q == CMAX) begin
          cnt_d   = '0;
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      CHECK: begin
        if (mismatch) begin
          err_d = err_q + (N_IN+1)'(1);
          if (!ffvalid_q) begin
            ffv_d     = vec_q;
            ffvalid_d = 1'b1;
          end
        end
`ifdef STOP_ON_FAIL_EN
        if (mismatch || vec_q == LAST) begin
          state_d = DONE;
        end else begin
          vec_d   = vec_q + N_IN'(1);
          state_d = APPLY;
        end
`else
        if (vec_q == LAST) begin
          state_d = DONE;
        end else begin
          vec_d   = vec_q + N_IN'(1);
          state_d = APPLY;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    // a/b/c follow the vector only while sweeping, so they are already correct on the first APPLY cycle
    abc_d = (state_d == APPLY || state_d == CHECK) ? vec_d : '0;
  end

  // State and result registers; reset aborts any sweep and discards partial results
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      vec_q     <= '0;
      cnt_q     <= '0;
      err_q     <= '0;
      ffv_q     <= '0;
      ffvalid_q <= 1'b0;
      abc_q     <= '0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      ffv_q     <= ffv_d;
      ffvalid_q <= ffvalid_d;
      abc_q     <= abc_d;
    end
  end

  assign a                = abc_q[2];
  assign b                = abc_q[1];
  assign c                = abc_q[0];
  assign busy             = (state_q == APPLY) || (state_q == CHECK);
  assign done             = (state_q == DONE);
  assign pass             = done && (err_q == '0);
  assign err_count        = err_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffvalid_q;

endmodule
